// File: rtl/ternary_dot_product.sv
// Ternary-weight dot-product tile: 32 ternary weights, byte-serial activations,
// signed 14-bit saturating accumulator.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   ena      design select, ignored
//   ui_in    data byte (4 weights or 8 activations)
//   uio_in   [1:0] command: 00 NOP, 01 LOAD_W, 10 LOAD_X, 11 CLEAR
//   uo_out   acc[7:0]
//   uio_out  {acc[13:8], 2'b00}
//   uio_oe   constant 8'hFC
module ternary_dot_product (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_LOADW = 2'b01;
  localparam logic [1:0] CMD_LOADX = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  logic [31:0]        w_pos;
  logic [31:0]        w_neg;
  logic [31:0]        x;
  logic [1:0]         cnt;
  logic signed [13:0] acc;

  logic [1:0]         cmd;
  logic [3:0]         pos4;
  logic [3:0]         neg4;
  logic [31:0]        v;
  logic [5:0]         pc_pos;
  logic [5:0]         pc_neg;
  logic signed [6:0]  d;
  logic signed [14:0] sum;
  logic signed [13:0] acc_sat;

  logic unused_bits;
  assign unused_bits = ^{ena, uio_in[7:2]};

  assign cmd = uio_in[1:0];

  // 01 -> +1, 11 -> -1, 00/10 -> 0
  always_comb begin
    pos4 = '0;
    neg4 = '0;
    for (int k = 0; k < 4; k++) begin
      pos4[k] = (ui_in[2*k +: 2] == 2'b01);
      neg4[k] = (ui_in[2*k +: 2] == 2'b11);
    end
  end

  // Vector as it will look once this byte is shifted in.
  assign v = {ui_in, x[31:8]};

  PopCount32 u_pc_pos (
    .data  (w_pos & v),
    .count (pc_pos)
  );

  PopCount32 u_pc_neg (
    .data  (w_neg & v),
    .count (pc_neg)
  );

  assign d = $signed({1'b0, pc_pos}) - $signed({1'b0, pc_neg});

  assign sum = {acc[13], acc} + {{8{d[6]}}, d};

  // Top two bits disagree only when the 15-bit sum left the 14-bit range.
  always_comb begin
    unique case (sum[14:13])
      2'b01:   acc_sat = 14'sh1FFF;
      2'b10:   acc_sat = 14'sh2000;
      default: acc_sat = sum[13:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_pos <= '0;
      w_neg <= '0;
      x     <= '0;
      cnt   <= '0;
      acc   <= '0;
    end else begin
      unique case (cmd)
        CMD_LOADW: begin
          w_pos <= {pos4, w_pos[31:4]};
          w_neg <= {neg4, w_neg[31:4]};
        end
        CMD_LOADX: begin
          x   <= v;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3)
            acc <= acc_sat;
        end
        CMD_CLEAR: begin
          acc <= '0;
          cnt <= '0;
        end
        CMD_NOP: ;
        default: ;
      endcase
    end
  end

  assign uo_out  = acc[7:0];
  assign uio_out = {acc[13:8], 2'b00};
  assign uio_oe  = 8'hFC;

endmodule

// Combinational 32-bit population count.
module PopCount32 (
  input  logic [31:0] data,
  output logic [5:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < 32; i++)
      count = count + {5'd0, data[i]};
  end

endmodule

// File: tb/tb_ternary_dot_product.sv
// Self-checking bench for ternary_dot_product against an
// integer reference model of the weights, vector and accumulator.
module tb_ternary_dot_product;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic [31:0] pc_data;
  logic [5:0]  pc_count;

  int tests  = 0;
  int failed = 0;

  int m_w[32];
  logic [31:0] m_x;
  int m_cnt;
  int m_acc;

  always #5 clk = ~clk;

  ternary_dot_product dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  PopCount32 u_pc (
    .data  (pc_data),
    .count (pc_count)
  );

  function automatic int wdec(input logic [1:0] b);
    if (b == 2'b01) return 1;
    if (b == 2'b11) return -1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_w[i] = 0;
    m_x   = '0;
    m_cnt = 0;
    m_acc = 0;
  endtask

  task automatic model_step(input logic [1:0] cmd, input logic [7:0] b);
    int s;
    logic [7:0] bb;
    bb = b;
    case (cmd)
      2'b01: begin
        for (int i = 0; i < 28; i++) m_w[i] = m_w[i+4];
        for (int k = 0; k < 4; k++) m_w[28+k] = wdec(bb[2*k +: 2]);
      end
      2'b10: begin
        m_x = {bb, m_x[31:8]};
        if (m_cnt == 3) begin
          s = m_acc;
          for (int i = 0; i < 32; i++)
            if (m_x[i]) s += m_w[i];
          if (s > 8191)  s = 8191;
          if (s < -8192) s = -8192;
          m_acc = s;
        end
        m_cnt = (m_cnt + 1) % 4;
      end
      2'b11: begin
        m_acc = 0;
        m_cnt = 0;
      end
      default: ;
    endcase
  endtask

  task automatic check(input string tag);
    logic [23:0] exp;
    logic [23:0] obs;
    logic [13:0] a;
    a   = m_acc[13:0];
    exp = {8'hFC, a[13:8], 2'b00, a[7:0]};
    obs = {uio_oe, uio_out, uo_out};
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s oe/uio/uo got %h exp %h (acc %0d)",
             tag, obs, exp, m_acc);
    end
  endtask

  task automatic step(input logic [1:0] cmd, input logic [7:0] b,
                      input string tag, input bit chk);
    @(negedge clk);
    rst    = 1'b0;
    uio_in = {$urandom_range(0, 63), cmd};
    ui_in  = b;
    @(posedge clk);
    model_step(cmd, b);
    #1;
    if (chk) check(tag);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst    = 1'b1;
    uio_in = {6'd0, 2'b10};
    ui_in  = 8'hFF;
    repeat (n) @(posedge clk);
    model_reset();
    #1;
    check("reset");
  endtask

  task automatic pc_check(input logic [31:0] dv, input logic [5:0] ev);
    pc_data = dv;
    #1;
    tests++;
    assert (pc_count === ev) else begin
      failed++;
      $error("FAIL popcount(%h) got %0d exp %0d", dv, pc_count, ev);
    end
  endtask

  initial begin
    rst    = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    pc_data = '0;
    model_reset();

    do_reset(2);
    repeat (3) step(2'b00, 8'hA5, "nop_after_reset", 1'b1);

    pc_check(32'h0000_0000, 6'd0);
    pc_check(32'hFFFF_FFFF, 6'd32);
    pc_check(32'h8000_0001, 6'd2);
    pc_check(32'h0F0F_0F0F, 6'd16);
    pc_check(32'hAAAA_AAAA, 6'd16);

    repeat (8) step(2'b01, 8'h55, "pos_loadw", 1'b1);
    repeat (4) step(2'b10, 8'hFF, "pos_loadx", 1'b1);

    step(2'b11, 8'h00, "clear", 1'b1);
    repeat (8) step(2'b01, 8'hFF, "neg_loadw", 1'b1);
    repeat (4) step(2'b10, 8'hFF, "neg_loadx", 1'b1);

    for (int i = 0; i < 8; i++)
      step(2'b01, (i % 2) ? 8'hAA : 8'h00, "mix_loadw", 1'b1);
    repeat (4) step(2'b10, 8'h0F, "mix_loadx", 1'b1);

    // Random weights, activations and interleaved commands.
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [1:0] c;
      r = $urandom_range(0, 99);
      c = (r < 30) ? 2'b01 : (r < 85) ? 2'b10 : (r < 95) ? 2'b00 : 2'b11;
      step(c, 8'($urandom), "random", 1'b1);
    end

    step(2'b11, 8'h00, "sat_clear", 1'b1);
    repeat (8) step(2'b01, 8'h55, "sat_loadw", 1'b0);
    repeat (256 * 4) step(2'b10, 8'hFF, "sat_pos", 1'b0);
    check("sat_pos_max");
    repeat (8) step(2'b10, 8'hFF, "sat_pos_hold", 1'b1);

    step(2'b11, 8'h00, "sat_clear2", 1'b1);
    repeat (8) step(2'b01, 8'hFF, "sat_loadw_neg", 1'b0);
    repeat (256 * 4) step(2'b10, 8'hFF, "sat_neg", 1'b0);
    check("sat_neg_256");
    repeat (4) step(2'b10, 8'hFF, "sat_neg_min", 1'b1);
    repeat (8) step(2'b10, 8'hFF, "sat_neg_hold", 1'b1);

    step(2'b11, 8'h00, "mid_clear0", 1'b1);
    repeat (8) step(2'b01, 8'h55, "mid_loadw", 1'b0);
    repeat (2) step(2'b10, 8'hFF, "mid_pre", 1'b1);
    step(2'b11, 8'h00, "mid_clear", 1'b1);
    step(2'b10, 8'hFF, "mid_post1", 1'b1);
    step(2'b00, 8'h00, "mid_nop", 1'b1);
    repeat (2) step(2'b10, 8'hFF, "mid_post23", 1'b1);
    step(2'b10, 8'hFF, "mid_post4", 1'b1);

    repeat (2) step(2'b10, 8'hFF, "rst_pre", 1'b1);
    do_reset(1);
    repeat (4) step(2'b10, 8'hFF, "rst_post", 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
